// File: rtl/extract_dispatch_pkg.sv
// Shared field layout and defaults for the leaf-side packet dispatcher.
// Packet layout from the MSB down: valid, leaf id, one gap bit, port.
package extract_dispatch_pkg;

    localparam int DEF_PACKET_BITS     = 97;
    localparam int DEF_NUM_LEAF_BITS   = 6;
    localparam int DEF_NUM_PORT_BITS   = 4;
    localparam int DEF_CFG_PORT_HI     = 1;
    localparam int DEF_OUTPUT_PORT_MIN = 9;

    function automatic int vld_pos(input int pb);
        return pb - 1;
    endfunction

    function automatic int leaf_lsb(input int pb, input int lb);
        return pb - 1 - lb;
    endfunction

    function automatic int port_lsb(input int pb, input int lb, input int nb);
        return pb - 1 - lb - 1 - nb;
    endfunction

    localparam int VLD_BIT  = vld_pos(DEF_PACKET_BITS);
    localparam int LEAF_MSB = VLD_BIT - 1;
    localparam int LEAF_LSB = leaf_lsb(DEF_PACKET_BITS, DEF_NUM_LEAF_BITS);
    localparam int PORT_MSB = LEAF_LSB - 2;
    localparam int PORT_LSB = port_lsb(DEF_PACKET_BITS, DEF_NUM_LEAF_BITS,
                                       DEF_NUM_PORT_BITS);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/extract_dispatch_fifo.sv
// Per-class packet FIFO; head reads as zero while empty.
// Caller only pushes when not full, or when popping on the same edge.
module leaf_pkt_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/extract_dispatch.sv
// Leaf-side dispatcher: classifies inbound BFT packets into config and
// stream FIFOs, drops on full with a resend pulse, registers outbound.
module extract_dispatch
    import extract_dispatch_pkg::*;
#(
    parameter int PACKET_BITS     = DEF_PACKET_BITS,
    parameter int NUM_LEAF_BITS   = DEF_NUM_LEAF_BITS,
    parameter int NUM_PORT_BITS   = DEF_NUM_PORT_BITS,
    parameter int CFG_PORT_HI     = DEF_CFG_PORT_HI,
    parameter int OUTPUT_PORT_MIN = DEF_OUTPUT_PORT_MIN,
    parameter int FIFO_DEPTH      = 4,
    parameter int LEAF_ID         = 0,
    parameter int CHECK_LEAF      = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [PACKET_BITS-1:0] din_leaf_bft2interface,
    input  logic                   resend,
    output logic                   resend_out,
    input  logic [PACKET_BITS-1:0] stream_in,
    output logic [PACKET_BITS-1:0] dout_leaf_interface2bft,
    output logic                   bft_resend_req,
    output logic [PACKET_BITS-1:0] stream_out,
    output logic                   stream_out_valid,
    input  logic                   stream_out_ready,
    output logic [PACKET_BITS-1:0] configure_out,
    output logic                   configure_out_valid,
    input  logic                   configure_out_ready,
    output logic [15:0]            drop_count,
    output logic [15:0]            misroute_count
);

    localparam int VLD_POS = vld_pos(PACKET_BITS);
    localparam int LF_LSB  = leaf_lsb(PACKET_BITS, NUM_LEAF_BITS);
    localparam int PT_LSB  = port_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [NUM_PORT_BITS-1:0] CFG_HI  = NUM_PORT_BITS'(CFG_PORT_HI);
    localparam logic [NUM_PORT_BITS-1:0] OUT_MIN = NUM_PORT_BITS'(OUTPUT_PORT_MIN);
    localparam logic [NUM_LEAF_BITS-1:0] MY_LEAF = NUM_LEAF_BITS'(LEAF_ID);

    logic                     vld;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic                     is_cfg;
    logic                     misroute;
    logic                     take;

    logic          cfg_full, cfg_empty, cfg_pop, cfg_push, cfg_room;
    logic          str_full, str_empty, str_pop, str_push, str_room;
    logic [CW-1:0] cfg_count, str_count;
    logic          reject;

    assign vld  = din_leaf_bft2interface[VLD_POS];
    assign leaf = din_leaf_bft2interface[LF_LSB +: NUM_LEAF_BITS];
    assign port = din_leaf_bft2interface[PT_LSB +: NUM_PORT_BITS];

    assign is_cfg   = (port <= CFG_HI) || (port >= OUT_MIN);
    assign misroute = (CHECK_LEAF != 0) && (leaf != MY_LEAF);
    assign take     = vld && !misroute;

    // A full FIFO still accepts when its head leaves on the same edge.
    assign cfg_pop  = configure_out_valid && configure_out_ready;
    assign str_pop  = stream_out_valid && stream_out_ready;
    assign cfg_room = !cfg_full || cfg_pop;
    assign str_room = !str_full || str_pop;
    assign cfg_push = take && is_cfg && cfg_room;
    assign str_push = take && !is_cfg && str_room;
    assign reject   = take && (is_cfg ? !cfg_room : !str_room);

    leaf_pkt_fifo #(.WIDTH(PACKET_BITS), .DEPTH(FIFO_DEPTH)) u_cfg_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cfg_push),
        .pop     (cfg_pop),
        .din     (din_leaf_bft2interface),
        .dout    (configure_out),
        .full    (cfg_full),
        .empty   (cfg_empty),
        .count   (cfg_count)
    );

    leaf_pkt_fifo #(.WIDTH(PACKET_BITS), .DEPTH(FIFO_DEPTH)) u_stream_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (str_push),
        .pop     (str_pop),
        .din     (din_leaf_bft2interface),
        .dout    (stream_out),
        .full    (str_full),
        .empty   (str_empty),
        .count   (str_count)
    );

    assign configure_out_valid = !cfg_empty;
    assign stream_out_valid    = !str_empty;
    assign resend_out          = resend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bft_resend_req          <= 1'b0;
            drop_count              <= '0;
            misroute_count          <= '0;
            dout_leaf_interface2bft <= '0;
        end else begin
            bft_resend_req          <= reject;
            dout_leaf_interface2bft <= stream_in;
            if (reject)
                drop_count <= sat_inc(drop_count);
            if (vld && misroute)
                misroute_count <= sat_inc(misroute_count);
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
        (cfg_count <= CW'(FIFO_DEPTH)) && (str_count <= CW'(FIFO_DEPTH)));

endmodule

// File: doc/extract_dispatch.md
# extract_dispatch

Parametrised leaf-side packet dispatcher between a BFT leaf port and the leaf's config and stream logic. Each valid inbound packet is classified by its port field into the config class or the stream class and queued in a per-class FIFO with a valid/ready handshake. When a packet arrives while its FIFO is full, the packet is dropped, a resend request is raised toward the BFT, and a drop counter is updated. An optional leaf-ID check discards misrouted packets; the outbound stream path is registered one stage.

## Interface
- PACKET_BITS, 97, packet width; MSB is the valid bit
- NUM_LEAF_BITS, 6, leaf field width
- NUM_PORT_BITS, 4, port field width
- CFG_PORT_HI, 1, ports 0..CFG_PORT_HI are config class
- OUTPUT_PORT_MIN, 9, ports ≥ this are config class; ports CFG_PORT_HI+1..OUTPUT_PORT_MIN-1 are stream class
- FIFO_DEPTH, 4, entries per class FIFO; power of two, ≥2
- LEAF_ID, 0, this leaf's address
- CHECK_LEAF, 0, 1 = drop packets whose leaf field ≠ LEAF_ID
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- din_leaf_bft2interface  in  PACKET_BITS  inbound packet from BFT, sampled every cycle
- resend  in  1  resend request from BFT
- resend_out  out  1  = resend, combinational
- stream_in  in  PACKET_BITS  outbound packet from stream flow control
- dout_leaf_interface2bft  out  PACKET_BITS  stream_in delayed one cycle
- bft_resend_req  out  1  one-cycle pulse: inbound packet dropped on full FIFO
- stream_out / configure_out  out  PACKET_BITS  FIFO head; all-zero when empty
- stream_out_valid / configure_out_valid  out  1  FIFO non-empty
- stream_out_ready / configure_out_ready  in  1  consumer pop
- drop_count  out  16  saturating full-FIFO drop count
- misroute_count  out  16  saturating leaf-mismatch drop count

## Operation
- Field decode: vld = bit [PACKET_BITS-1]. leaf = next NUM_LEAF_BITS bits below vld. One gap bit follows leaf. port = the NUM_PORT_BITS bits below the gap bit.
- Class: config if port ≤ CFG_PORT_HI or port ≥ OUTPUT_PORT_MIN; otherwise stream. Exactly one class per packet.
- Invalid packets (vld=0) are ignored, with no counter or FIFO effect.
- Misroute: if CHECK_LEAF=1 and leaf ≠ LEAF_ID, the packet is discarded, misroute_count increments, and bft_resend_req is not asserted.
- Accept: target FIFO accepts if count < FIFO_DEPTH, or if count = FIFO_DEPTH and a pop occurs on the same edge (pop then push).
- Reject: drop_count increments and bft_resend_req pulses on the next cycle. FIFO contents are unchanged.
- Pop: valid && ready at the edge removes the head.
- Counters saturate at 16'hFFFF and never wrap.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset (async assert, sync release): FIFOs empty; all data outputs 0; valids 0; bft_resend_req 0; counters 0; dout_leaf_interface2bft 0.
- Inbound latency: a packet sampled at edge N appears on the head output with valid=1 after edge N if its FIFO was empty, i.e. 1 cycle.
- bft_resend_req is registered and is high for the cycle after the rejecting edge.
- Back-to-back valid packets are accepted every cycle while space remains.
- Push and pop on the same edge with count=1 leave count=1, and the new packet becomes the head.
- Outbound: dout_leaf_interface2bft(N+1) = stream_in(N).
- Reset asserted mid-transfer discards queued packets immediately. No partial output is held.

## Structure
- Shared package: field-offset localparams (VLD_BIT, LEAF_MSB/LSB, PORT_MSB/LSB) derived from PACKET_BITS, NUM_LEAF_BITS and NUM_PORT_BITS, plus the default CFG_PORT_HI and OUTPUT_PORT_MIN.
- Sub-module: leaf_pkt_fifo, instantiated twice. It has parameters WIDTH and DEPTH; ports push, pop, din, dout (zero when empty), full, empty, count; and it takes the same clk/reset_n.
- The top level holds decode, classify, accept/reject, counters and the outbound register.

## Test plan
- After reset, send port=3 vld=1 packet 0x1_0C..AB → stream_out equals packet one cycle later with stream_out_valid=1; configure_out_valid stays 0.
- Ports 0, 1, 9 and 15 each → configure FIFO, in order; port 8 → stream FIFO; vld=0 with port=0 → nothing.
- FIFO_DEPTH=4, ready=0, 5 stream packets → first 4 held; fifth dropped; drop_count=1; bft_resend_req high exactly one cycle.
- Full FIFO with ready=1 and a new packet on the same edge → accepted, count stays 4, drop_count unchanged.
- CHECK_LEAF=1, LEAF_ID=5, packet leaf=6 → dropped; misroute_count=1; no resend pulse. Separately, 70000 forced drops → drop_count=16'hFFFF.
- Assert reset_n low mid-queue with 3 entries → valids 0 and outputs 0 immediately. stream_in=0xAA.. → dout_leaf_interface2bft shows it one cycle later.
